aq_axi_wr_packer: RTL and testbench

- Write-side feeder for the 64-bit AXI burst master.
- Accepts a 32-bit valid/ready pixel/data stream and packs word pairs into 64-bit beats.
- Buffers beats in a first-word-fall-through (FWFT) FIFO.
- Presents the master's local write-FIFO interface: data, empty, almost-empty and read-enable.

---
 rtl/aq_axi_wr_packer.sv | 127 ++++++++++++
 tb/tb_aq_axi_wr_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_axi_wr_packer.sv
// aq_axi_wr_packer: packs a 32-bit valid/ready word stream into 64-bit beats
// and buffers them in a first-word-fall-through FIFO. The FIFO feeds the write
// side of the 64-bit AXI burst master.
// Optional build macro AQ_WR_PACK_BSWAP_EN: when defined, each input word is
// byte-reversed before packing, for big-endian sources. The pad word is not swapped.
module aq_axi_wr_packer #(
  parameter int          ADDR_W    = 9,
  parameter int          AEMPTY_TH = 256,
  parameter logic [31:0] PAD_DATA  = 32'h0000_0000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              FLUSH,
  input  logic [31:0]       S_DATA,
  input  logic              S_VALID,
  input  logic              S_LAST,
  output logic              S_READY,
  input  logic              WR_FIFO_RE,
  output logic [63:0]       WR_FIFO_DATA,
  output logic              WR_FIFO_EMPTY,
  output logic              WR_FIFO_AEMPTY,
  output logic [ADDR_W:0]   WR_FIFO_LEVEL,
  output logic              OVERRUN
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] LVL_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Which half of the 64-bit beat the next accepted word fills.
  typedef enum logic {PACK_LO = 1'b0, PACK_HI = 1'b1} pack_state_t;

  pack_state_t       pack_half;
  logic [31:0]       lo_reg;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [63:0]       mem [DEPTH];

  logic [31:0]       word;
  logic              accept;
  logic              push;
  logic              pop;
  logic [63:0]       push_data;
  logic [ADDR_W:0]   level_nxt;

  // Optional byte reversal of the incoming word ahead of the packer.
  always_comb begin
`ifdef AQ_WR_PACK_BSWAP_EN
    word = {S_DATA[7:0], S_DATA[15:8], S_DATA[23:16], S_DATA[31:24]};
`else
    word = S_DATA;
`endif
  end

  // Handshake decode, beat assembly and next-state level.
  always_comb begin
    accept    = S_VALID & S_READY;
    push      = accept & ((pack_half == PACK_HI) | S_LAST);
    pop       = WR_FIFO_RE & ~WR_FIFO_EMPTY;
    push_data = (pack_half == PACK_HI) ? {word, lo_reg} : {PAD_DATA, word};
    level_nxt = WR_FIFO_LEVEL;
    case ({push, pop})
      2'b10:   level_nxt = WR_FIFO_LEVEL + LVL_ONE;
      2'b01:   level_nxt = WR_FIFO_LEVEL - LVL_ONE;
      default: level_nxt = WR_FIFO_LEVEL;
    endcase
  end

  // Beat storage; the head is read combinationally for fall-through behaviour.
  always_ff @(posedge ACLK) begin
    if (push && !FLUSH) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign WR_FIFO_DATA = mem[rd_ptr];

  // Pack state, pointers, level and status flags; FLUSH mirrors reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pack_half      <= PACK_LO;
      lo_reg         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      WR_FIFO_LEVEL  <= '0;
      WR_FIFO_EMPTY  <= 1'b1;
      WR_FIFO_AEMPTY <= 1'b1;
      S_READY        <= 1'b1;
      OVERRUN        <= 1'b0;
    end else if (FLUSH) begin
      pack_half      <= PACK_LO;
      lo_reg         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      WR_FIFO_LEVEL  <= '0;
      WR_FIFO_EMPTY  <= 1'b1;
      WR_FIFO_AEMPTY <= 1'b1;
      S_READY        <= 1'b1;
      OVERRUN        <= 1'b0;
    end else begin
      if (accept) begin
        if (pack_half == PACK_HI) begin
          pack_half <= PACK_LO;
        end else if (!S_LAST) begin
          lo_reg    <= word;
          pack_half <= PACK_HI;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (WR_FIFO_RE && WR_FIFO_EMPTY) begin
        OVERRUN <= 1'b1;
      end
      WR_FIFO_LEVEL  <= level_nxt;
      WR_FIFO_EMPTY  <= (level_nxt == '0);
      WR_FIFO_AEMPTY <= (level_nxt < AEMPTY_LVL);
      S_READY        <= (level_nxt != FULL_LVL);
    end
  end

endmodule

// File: tb/tb_aq_axi_wr_packer.sv
// tb_aq_axi_wr_packer: directed and randomized stimulus for aq_axi_wr_packer,
// checked by a queue-based scoreboard against a word-level reference model.
module tb_aq_axi_wr_packer;

  localparam int          ADDR_W    = 9;
  localparam int          DEPTH     = 512;
  localparam int          AEMPTY_TH = 256;
  localparam logic [31:0] PAD       = 32'h0000_0000;

  logic              ACLK       = 1'b0;
  logic              ARESETN    = 1'b0;
  logic              FLUSH      = 1'b0;
  logic [31:0]       S_DATA     = '0;
  logic              S_VALID    = 1'b0;
  logic              S_LAST     = 1'b0;
  logic              WR_FIFO_RE = 1'b0;
  logic              S_READY;
  logic [63:0]       WR_FIFO_DATA;
  logic              WR_FIFO_EMPTY;
  logic              WR_FIFO_AEMPTY;
  logic [ADDR_W:0]   WR_FIFO_LEVEL;
  logic              OVERRUN;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected beats in FIFO order plus the pending half word.
  logic [63:0] exp_q[$];
  logic        model_half;
  logic [31:0] model_lo;
  logic        model_overrun;
  int          lvl;
  logic [31:0] mw;

  aq_axi_wr_packer #(
    .ADDR_W    (ADDR_W),
    .AEMPTY_TH (AEMPTY_TH),
    .PAD_DATA  (PAD)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .FLUSH          (FLUSH),
    .S_DATA         (S_DATA),
    .S_VALID        (S_VALID),
    .S_LAST         (S_LAST),
    .S_READY        (S_READY),
    .WR_FIFO_RE     (WR_FIFO_RE),
    .WR_FIFO_DATA   (WR_FIFO_DATA),
    .WR_FIFO_EMPTY  (WR_FIFO_EMPTY),
    .WR_FIFO_AEMPTY (WR_FIFO_AEMPTY),
    .WR_FIFO_LEVEL  (WR_FIFO_LEVEL),
    .OVERRUN        (OVERRUN)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] model_word(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef AQ_WR_PACK_BSWAP_EN
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = w[8*(3-b) +: 8];
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return just after the clock edge that consumes them.
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last,
                               input logic re, input logic flush);
    S_VALID    = valid;
    S_DATA     = data;
    S_LAST     = last;
    WR_FIFO_RE = re;
    FLUSH      = flush;
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: at each falling edge compare status and popped data with the model,
  // then apply the handshakes that the coming rising edge will perform.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      exp_q.delete();
      model_half    = 1'b0;
      model_lo      = '0;
      model_overrun = 1'b0;
    end else begin
      lvl = exp_q.size();
      checkOutput("level",   64'(WR_FIFO_LEVEL),  64'(lvl));
      checkOutput("empty",   64'(WR_FIFO_EMPTY),  64'(lvl == 0));
      checkOutput("aempty",  64'(WR_FIFO_AEMPTY), 64'(lvl < AEMPTY_TH));
      checkOutput("s_ready", 64'(S_READY),        64'(lvl != DEPTH));
      checkOutput("overrun", 64'(OVERRUN),        64'(model_overrun));
      if (FLUSH) begin
        exp_q.delete();
        model_half    = 1'b0;
        model_lo      = '0;
        model_overrun = 1'b0;
      end else begin
        if (WR_FIFO_RE) begin
          if (lvl == 0) begin
            model_overrun = 1'b1;
          end else begin
            checkOutput("data", WR_FIFO_DATA, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        if (S_VALID && lvl != DEPTH) begin
          mw = model_word(S_DATA);
          if (model_half) begin
            exp_q.push_back({mw, model_lo});
            model_half = 1'b0;
          end else if (S_LAST) begin
            exp_q.push_back({PAD, mw});
          end else begin
            model_lo   = mw;
            model_half = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int unsigned cnt;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // Reset state
    checkOutput("rst_empty",   64'(WR_FIFO_EMPTY),  64'(1));
    checkOutput("rst_aempty",  64'(WR_FIFO_AEMPTY), 64'(1));
    checkOutput("rst_level",   64'(WR_FIFO_LEVEL),  64'(0));
    checkOutput("rst_s_ready", 64'(S_READY),        64'(1));
    checkOutput("rst_overrun", 64'(OVERRUN),        64'(0));

    // Packing and lane order
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    checkOutput("pack_half_empty", 64'(WR_FIFO_EMPTY), 64'(1));
    applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    checkOutput("pack_empty_fall", 64'(WR_FIFO_EMPTY), 64'(0));
    checkOutput("pack_beat0", WR_FIFO_DATA, 64'h2222_2222_1111_1111);
    applyStimulus(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
    checkOutput("pack_level2", 64'(WR_FIFO_LEVEL), 64'(2));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("pack_beat1", WR_FIFO_DATA, 64'h0000_0000_3333_3333);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("pack_drained", 64'(WR_FIFO_EMPTY), 64'(1));

    // Byte order option
    applyStimulus(1'b1, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
`ifdef AQ_WR_PACK_BSWAP_EN
    checkOutput("bswap_beat", WR_FIFO_DATA, 64'h4433_2211_DDCC_BBAA);
`else
    checkOutput("bswap_beat", WR_FIFO_DATA, 64'h1122_3344_AABB_CCDD);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Fill to full with no pops
    for (int i = 0; i < 2 * DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      if (i == 2 * AEMPTY_TH - 3) checkOutput("aempty_below_th", 64'(WR_FIFO_AEMPTY), 64'(1));
      if (i == 2 * AEMPTY_TH - 1) checkOutput("aempty_at_th", 64'(WR_FIFO_AEMPTY), 64'(0));
    end
    checkOutput("full_level",   64'(WR_FIFO_LEVEL), 64'(DEPTH));
    checkOutput("full_s_ready", 64'(S_READY),       64'(0));
    applyStimulus(1'b1, 32'd1024, 1'b0, 1'b1, 1'b0);
    checkOutput("pop_full_s_ready", 64'(S_READY),       64'(1));
    checkOutput("pop_full_level",   64'(WR_FIFO_LEVEL), 64'(DEPTH - 1));
    applyStimulus(1'b1, 32'd1024, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd1025, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_empty", 64'(WR_FIFO_EMPTY), 64'(1));

    // Pop while empty
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("overrun_set",   64'(OVERRUN),       64'(1));
    checkOutput("overrun_level", 64'(WR_FIFO_LEVEL), 64'(0));
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    checkOutput("overrun_next_beat", WR_FIFO_DATA, {PAD, model_word(32'hCAFE_F00D)});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("overrun_sticky", 64'(OVERRUN), 64'(1));

    // Flush clears FIFO, pack state and the sticky flag
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("preflush_level", 64'(WR_FIFO_LEVEL), 64'(3));
    applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_empty",   64'(WR_FIFO_EMPTY), 64'(1));
    checkOutput("flush_level",   64'(WR_FIFO_LEVEL), 64'(0));
    checkOutput("flush_overrun", 64'(OVERRUN),       64'(0));
    applyStimulus(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8888_8888, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_half_discard", WR_FIFO_DATA, 64'h9999_9999_8888_8888);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Concurrent push and pop across pointer wrap
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, cnt, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'b1, cnt, 1'b1, 1'b1, 1'b0);
      cnt++;
    end
    checkOutput("wrap_level", 64'(WR_FIFO_LEVEL), 64'(4));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
